rst_ctl: RTL and testbench



---
 rtl/rst_ctl.sv | 175 +++++++++++++++++
 tb/tb_rst_ctl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_ctl.sv
// Reset and clock-configuration sequencer (clock_160 domain): stretches board/software reset
// and stages clock-mode changes so CLKSEL moves only after a new oscillator/PLL settles.
// Optional macro RST_CAUSE_EN enables the rst_cause register; otherwise rst_cause reads 2'b00.
module rst_ctl #(
  parameter int POR_CYCLES    = 1024,
  parameter int SW_CYCLES     = 16,
  parameter int SETTLE_CYCLES = 4096,
  parameter int CNT_W         = 16
) (
  input  logic       clock_160,
  input  logic       inp_resn,
  input  logic [7:0] cfg,
  output logic       nres,
  output logic [6:0] clk_cfg,
  output logic       busy,
  output logic [1:0] rst_cause
);

  typedef enum logic [1:0] {
    ST_POR   = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWRST = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             r_sync1, r_sync2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_scnt, w_scnt_nxt;
  logic             r_settling, w_settling_nxt;
  logic             r_nres, w_nres_nxt;
  logic [6:0]       r_clk_cfg, w_clk_cfg_nxt;
  logic [6:0]       w_new;
  logic             w_en_rise;

  assign w_new     = cfg[6:0];
  assign w_en_rise = (w_new[6] & ~r_clk_cfg[6]) | (w_new[5] & ~r_clk_cfg[5]);

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= 1'b1;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      r_state    <= ST_POR;
      r_cnt      <= '0;
      r_scnt     <= '0;
      r_settling <= 1'b0;
      r_nres     <= 1'b0;
      r_clk_cfg  <= 7'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_scnt     <= w_scnt_nxt;
      r_settling <= w_settling_nxt;
      r_nres     <= w_nres_nxt;
      r_clk_cfg  <= w_clk_cfg_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_scnt_nxt     = r_scnt;
    w_settling_nxt = r_settling;
    w_nres_nxt     = r_nres;
    w_clk_cfg_nxt  = r_clk_cfg;

    // A low synchronised reset overrides everything, whatever the state.
    if (!r_sync2) begin
      w_state_nxt    = ST_POR;
      w_cnt_nxt      = '0;
      w_scnt_nxt     = '0;
      w_settling_nxt = 1'b0;
      w_nres_nxt     = 1'b0;
      w_clk_cfg_nxt  = 7'h00;
    end else begin
      case (r_state)
        ST_POR: begin
          if (r_cnt == POR_LAST) begin
            w_state_nxt = ST_RUN;
            w_nres_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        ST_RUN: begin
          if (cfg[7]) begin
            w_state_nxt    = ST_SWRST;
            w_nres_nxt     = 1'b0;
            w_clk_cfg_nxt  = 7'h00;
            w_settling_nxt = 1'b0;
            w_scnt_nxt     = '0;
            w_cnt_nxt      = '0;
          end else if (r_settling) begin
            if (w_new[6:3] != r_clk_cfg[6:3]) begin
              w_clk_cfg_nxt[6:3] = w_new[6:3];
              w_scnt_nxt         = '0;
            end else if (r_scnt == SETTLE_LAST) begin
              w_clk_cfg_nxt[2:0] = w_new[2:0];
              w_settling_nxt     = 1'b0;
            end else begin
              w_scnt_nxt = r_scnt + CNT_ONE;
            end
          end else if (w_new != r_clk_cfg) begin
            // CLKSEL waits for a newly enabled source; other changes apply at once.
            if (w_en_rise) begin
              w_clk_cfg_nxt[6:3] = w_new[6:3];
              w_scnt_nxt         = '0;
              w_settling_nxt     = 1'b1;
            end else begin
              w_clk_cfg_nxt = w_new;
            end
          end
        end

        ST_SWRST: begin
          if (r_cnt == SW_LAST) begin
            if (!cfg[7]) begin
              w_state_nxt = ST_RUN;
              w_nres_nxt  = 1'b1;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = ST_POR;
          w_cnt_nxt   = '0;
          w_nres_nxt  = 1'b0;
        end
      endcase
    end
  end

`ifdef RST_CAUSE_EN
  logic [1:0] r_cause, w_cause_nxt;

  always_comb begin
    w_cause_nxt = r_cause;
    if (w_state_nxt == ST_POR && r_state != ST_POR)
      w_cause_nxt = 2'b01;
    else if (w_state_nxt == ST_SWRST && r_state != ST_SWRST)
      w_cause_nxt = 2'b10;
  end

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) r_cause <= 2'b01;
    else           r_cause <= w_cause_nxt;
  end

  assign rst_cause = r_cause;
`else
  assign rst_cause = 2'b00;
`endif

  assign nres    = r_nres;
  assign clk_cfg = r_clk_cfg;
  assign busy    = (r_state != ST_RUN) | r_settling;

endmodule

// File: tb/tb_rst_ctl.sv
// Directed bench for rst_ctl with POR_CYCLES=8, SW_CYCLES=4, SETTLE_CYCLES=6.
// Expected rst_cause follows the RST_CAUSE_EN build option.
module tb_rst_ctl;

  logic       clk;
  logic       inp_resn;
  logic [7:0] cfg;
  logic       nres;
  logic [6:0] clk_cfg;
  logic       busy;
  logic [1:0] rst_cause;

  int errors = 0;
  int checks = 0;

`ifdef RST_CAUSE_EN
  localparam logic [1:0] EXP_POR = 2'b01;
  localparam logic [1:0] EXP_SW  = 2'b10;
`else
  localparam logic [1:0] EXP_POR = 2'b00;
  localparam logic [1:0] EXP_SW  = 2'b00;
`endif

  rst_ctl #(
    .POR_CYCLES(8),
    .SW_CYCLES(4),
    .SETTLE_CYCLES(6),
    .CNT_W(16)
  ) dut (
    .clock_160(clk),
    .inp_resn (inp_resn),
    .cfg      (cfg),
    .nres     (nres),
    .clk_cfg  (clk_cfg),
    .busy     (busy),
    .rst_cause(rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and returns the edge on which nres rose (-1 if it never did).
  task automatic release_and_count(output int edges);
    edges = -1;
    inp_resn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (nres === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int e;
    inp_resn = 1'b1;
    cfg = 8'h00;
    tick();
    inp_resn = 1'b0;
    #1;
    checks++;
    if (nres !== 1'b0 || clk_cfg !== 7'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: nres=%b clk_cfg=%h busy=%b, want 0 00 1", nres, clk_cfg, busy);
    end
    checks++;
    if (rst_cause !== EXP_POR) begin
      errors++;
      $display("FAIL reset_cause: got %b want %b", rst_cause, EXP_POR);
    end
    repeat (3) tick();
    release_and_count(e);
    checks++;
    if (e !== 10) begin
      errors++;
      $display("FAIL por_release_edge: nres rose on edge %0d, want 10", e);
    end
    checks++;
    if (busy !== 1'b0 || clk_cfg !== 7'h00 || rst_cause !== EXP_POR) begin
      errors++;
      $display("FAIL por_run_state: busy=%b clk_cfg=%h cause=%b, want 0 00 %b",
               busy, clk_cfg, rst_cause, EXP_POR);
    end
  endtask

  task automatic test_swreset();
    cfg = 8'h80;
    tick();
    checks++;
    if (nres !== 1'b0 || clk_cfg !== 7'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL swrst_entry: nres=%b clk_cfg=%h busy=%b, want 0 00 1", nres, clk_cfg, busy);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 1) cfg = 8'h00;
      checks++;
      if (nres !== 1'b0) begin
        errors++;
        $display("FAIL swrst_hold edge %0d: nres=%b want 0", i, nres);
      end
    end
    tick();
    checks++;
    if (nres !== 1'b1 || busy !== 1'b0 || rst_cause !== EXP_SW) begin
      errors++;
      $display("FAIL swrst_exit: nres=%b busy=%b cause=%b, want 1 0 %b", nres, busy, rst_cause, EXP_SW);
    end
    cfg = 8'h80;
    for (int i = 0; i <= 9; i++) begin
      tick();
      checks++;
      if (nres !== 1'b0) begin
        errors++;
        $display("FAIL swrst_long edge %0d: nres=%b want 0", i, nres);
      end
    end
    cfg = 8'h00;
    tick();
    checks++;
    if (nres !== 1'b1) begin
      errors++;
      $display("FAIL swrst_long_exit: nres=%b want 1", nres);
    end
  endtask

  task automatic test_settle();
    cfg = 8'h6F;
    tick();
    checks++;
    if (clk_cfg !== 7'h68 || busy !== 1'b1) begin
      errors++;
      $display("FAIL settle_start: clk_cfg=%h busy=%b, want 68 1", clk_cfg, busy);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (clk_cfg !== 7'h68 || busy !== 1'b1) begin
        errors++;
        $display("FAIL settle_hold %0d: clk_cfg=%h busy=%b, want 68 1", i, clk_cfg, busy);
      end
    end
    tick();
    checks++;
    if (clk_cfg !== 7'h6F || busy !== 1'b0) begin
      errors++;
      $display("FAIL settle_done: clk_cfg=%h busy=%b, want 6F 0", clk_cfg, busy);
    end
  endtask

  task automatic test_no_enable();
    cfg = 8'h6E;
    tick();
    checks++;
    if (clk_cfg !== 7'h6E || busy !== 1'b0) begin
      errors++;
      $display("FAIL direct_apply: clk_cfg=%h busy=%b, want 6E 0", clk_cfg, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL direct_busy: busy=%b want 0", busy);
    end
  endtask

  task automatic test_settle_update();
    cfg = 8'h00;
    tick();
    checks++;
    if (clk_cfg !== 7'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL disable_apply: clk_cfg=%h busy=%b, want 00 0", clk_cfg, busy);
    end
    cfg = 8'h6F;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) cfg = 8'h6B;
      checks++;
      if (clk_cfg !== 7'h68 || busy !== 1'b1) begin
        errors++;
        $display("FAIL sel_update_hold %0d: clk_cfg=%h busy=%b, want 68 1", i, clk_cfg, busy);
      end
    end
    tick();
    checks++;
    if (clk_cfg !== 7'h6B || busy !== 1'b0) begin
      errors++;
      $display("FAIL sel_update_done: clk_cfg=%h busy=%b, want 6B 0", clk_cfg, busy);
    end
    cfg = 8'h2B;
    tick();
    checks++;
    if (clk_cfg !== 7'h2B || busy !== 1'b0) begin
      errors++;
      $display("FAIL pll_off: clk_cfg=%h busy=%b, want 2B 0", clk_cfg, busy);
    end
    cfg = 8'h6B;
    tick();
    checks++;
    if (clk_cfg !== 7'h6B || busy !== 1'b1) begin
      errors++;
      $display("FAIL pll_on: clk_cfg=%h busy=%b, want 6B 1", clk_cfg, busy);
    end
    repeat (2) tick();
    cfg = 8'h2B;
    tick();
    checks++;
    if (clk_cfg !== 7'h2B || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_off: clk_cfg=%h busy=%b, want 2B 1", clk_cfg, busy);
    end
    cfg = 8'h6B;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL restart_hold %0d: busy=%b want 1", i, busy);
      end
    end
    tick();
    checks++;
    if (clk_cfg !== 7'h6B || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: clk_cfg=%h busy=%b, want 6B 0", clk_cfg, busy);
    end
  endtask

  task automatic test_swrst_priority();
    cfg = 8'hAF;
    tick();
    checks++;
    if (nres !== 1'b0 || clk_cfg !== 7'h00) begin
      errors++;
      $display("FAIL prio_entry: nres=%b clk_cfg=%h, want 0 00", nres, clk_cfg);
    end
    cfg = 8'h00;
    repeat (4) tick();
    checks++;
    if (nres !== 1'b1 || clk_cfg !== 7'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_exit: nres=%b clk_cfg=%h busy=%b, want 1 00 0", nres, clk_cfg, busy);
    end
  endtask

  task automatic test_async_mid();
    int e;
    cfg = 8'h6F;
    repeat (2) tick();
    #2 inp_resn = 1'b0;
    #1;
    checks++;
    if (nres !== 1'b0 || clk_cfg !== 7'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_settle: nres=%b clk_cfg=%h busy=%b, want 0 00 1", nres, clk_cfg, busy);
    end
    cfg = 8'h00;
    tick();
    release_and_count(e);
    checks++;
    if (e !== 10) begin
      errors++;
      $display("FAIL async_settle_release: nres rose on edge %0d, want 10", e);
    end
    cfg = 8'h80;
    repeat (2) tick();
    #2 inp_resn = 1'b0;
    #1;
    checks++;
    if (nres !== 1'b0 || clk_cfg !== 7'h00 || busy !== 1'b1 || rst_cause !== EXP_POR) begin
      errors++;
      $display("FAIL async_swrst: nres=%b clk_cfg=%h busy=%b cause=%b, want 0 00 1 %b",
               nres, clk_cfg, busy, rst_cause, EXP_POR);
    end
    cfg = 8'h00;
    tick();
    release_and_count(e);
    checks++;
    if (e !== 10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_swrst_release: edge %0d busy=%b, want 10 0", e, busy);
    end
  endtask

  initial begin
    inp_resn = 1'b1;
    cfg = 8'h00;
    test_reset();
    test_swreset();
    test_settle();
    test_no_enable();
    test_settle_update();
    test_swrst_priority();
    test_async_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
